// File: rtl/udma_apb_cmd_pkg.sv
// Shared types for the uDMA APB command master: command/response payloads and FSM encoding.
package udma_apb_cmd_pkg;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;

  // One queued APB command
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic                  write;
  } cmd_t;

  // One completed-transfer response
  typedef struct packed {
    logic [CMD_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  // FSM encoding kept as plain constants for legacy tool compatibility
  typedef logic [1:0] state_e;
  localparam state_e ST_IDLE   = 2'd0;
  localparam state_e ST_SETUP  = 2'd1;
  localparam state_e ST_ACCESS = 2'd2;
  localparam state_e ST_RESP   = 2'd3;

endpackage

// File: rtl/udma_apb_cmd_fifo.sv
// Small synchronous command FIFO; head entry is visible without popping.
module udma_apb_cmd_fifo
  import udma_apb_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  cmd_t push_data_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // State registers with async flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/udma_apb_cmd_master.sv
// APB initiator that executes queued register commands one transfer at a time
// and returns {rdata, err, timeout} on a valid/ready response port.
module udma_apb_cmd_master
  import udma_apb_cmd_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_resetn_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  input  logic                      cmd_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [31:0]               apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [31:0]               apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  cmd_t                      push_cmd;
  cmd_t                      head_cmd;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      timeout_hit_c;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  rsp_t                      rsp_q, rsp_d;

  // Command intake: ready depends on FIFO fullness only, never on a same-cycle pop
  assign cmd_ready_o    = !fifo_full;
  assign push           = cmd_valid_i && !fifo_full;
  assign push_cmd.addr  = CMD_ADDR_W'(cmd_addr_i);
  assign push_cmd.wdata = cmd_wdata_i;
  assign push_cmd.write = cmd_write_i;

  udma_apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk         (sys_clk_i),
    .rst_n       (sys_resetn_i),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .head_o      (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Last permitted wait cycle reached; a zero budget disables the abort entirely
  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and registered-output logic for the APB transfer sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    pop         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          paddr_d  = APB_ADDR_WIDTH'(head_cmd.addr);
          pwdata_d = head_cmd.wdata;
          pwrite_d = head_cmd.write;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (apb_pready_i) begin
          rsp_d.rdata   = pwrite_q ? 32'd0 : apb_prdata_i;
          rsp_d.err     = apb_pslverr_i;
          rsp_d.timeout = 1'b0;
          rsp_valid_d   = 1'b1;
          pop           = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cnt_d         = '0;
          state_d       = ST_RESP;
        end else if (timeout_hit_c) begin
          rsp_d.rdata   = 32'd0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          rsp_valid_d   = 1'b1;
          pop           = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          cnt_d         = '0;
          state_d       = ST_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            paddr_d  = APB_ADDR_WIDTH'(head_cmd.addr);
            pwdata_d = head_cmd.wdata;
            pwrite_d = head_cmd.write;
            psel_d   = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, APB drive and response registers
  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_udma_apb_cmd_master.sv
// Bench for udma_apb_cmd_master: directed timing scenarios plus a randomized
// command stream checked against an in-order register-file reference model.
module tb_udma_apb_cmd_master;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic          sys_clk_i = 1'b0;
  logic          sys_resetn_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [31:0]   cmd_wdata_i;
  logic          cmd_write_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic          busy_o;
  logic [AW-1:0] apb_paddr_o;
  logic [31:0]   apb_pwdata_o;
  logic          apb_pwrite_o;
  logic          apb_psel_o;
  logic          apb_penable_o;
  logic [31:0]   apb_prdata_i;
  logic          apb_pready_i;
  logic          apb_pslverr_i;

  always #5 sys_clk_i = ~sys_clk_i;

  udma_apb_cmd_master #(
    .APB_ADDR_WIDTH (AW),
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk_i     (sys_clk_i),
    .sys_resetn_i  (sys_resetn_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .cmd_write_i   (cmd_write_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o),
    .apb_paddr_o   (apb_paddr_o),
    .apb_pwdata_o  (apb_pwdata_o),
    .apb_pwrite_o  (apb_pwrite_o),
    .apb_psel_o    (apb_psel_o),
    .apb_penable_o (apb_penable_o),
    .apb_prdata_i  (apb_prdata_i),
    .apb_pready_i  (apb_pready_i),
    .apb_pslverr_i (apb_pslverr_i)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- APB slave model ----------------
  int  ws_fixed = 0;
  bit  rand_ws  = 1'b0;
  bit  stuck    = 1'b0;
  int  acc_cnt  = 0;
  int  cur_ws   = 0;
  logic [31:0] smem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h1A10_2084) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic err_rule(input logic [31:0] a);
    return (a[7:0] == 8'hEC);
  endfunction

  always @(negedge sys_clk_i) begin
    if (apb_psel_o && apb_penable_o) begin
      if (acc_cnt == 0) cur_ws = rand_ws ? int'($urandom_range(0, 2)) : ws_fixed;
      if (!stuck && acc_cnt >= cur_ws) begin
        apb_pready_i  = 1'b1;
        apb_pslverr_i = err_rule(apb_paddr_o);
        apb_prdata_i  = smem.exists(apb_paddr_o) ? smem[apb_paddr_o] : dflt(apb_paddr_o);
        if (apb_pwrite_o && !apb_pslverr_i) smem[apb_paddr_o] = apb_pwdata_o;
      end else begin
        apb_pready_i  = 1'b0;
        apb_pslverr_i = 1'b0;
        apb_prdata_i  = $urandom;
      end
      acc_cnt++;
    end else begin
      apb_pready_i  = 1'b0;
      apb_pslverr_i = 1'b0;
      apb_prdata_i  = 32'd0;
      acc_cnt       = 0;
    end
  end

  // ---------------- cycle helper / response collector ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_s;

  rsp_s got_q[$];
  int   got_t[$];
  int   cyc      = 0;
  bit   push_acc = 1'b0;
  bit   ready_s  = 1'b0;

  // Advance one clock; sample handshakes mid-cycle and return at posedge+1
  task automatic tick();
    @(negedge sys_clk_i);
    ready_s  = cmd_ready_o;
    push_acc = cmd_valid_i && cmd_ready_o;
    if (rsp_valid_o && rsp_ready_i) begin
      got_q.push_back('{rsp_rdata_o, rsp_err_o, rsp_timeout_o});
      got_t.push_back(cyc);
    end
    @(posedge sys_clk_i);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w);
    bit ok = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    cmd_write_i = w;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (push_acc) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid_i = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept addr=%h got=not_accepted exp=accepted", a);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_resetn_i = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_addr_i   = '0;
    cmd_wdata_i  = '0;
    cmd_write_i  = 1'b0;
    rsp_ready_i  = 1'b0;
    tick();
    tick();
    checks++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o, apb_paddr_o,
         apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got psel=%b pen=%b rv=%b busy=%b paddr=%h exp=all_zero",
               apb_psel_o, apb_penable_o, rsp_valid_o, busy_o, apb_paddr_o);
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_o);
    end
    sys_resetn_i = 1'b1;
    tick();
  endtask

  task automatic test_write_latency();
    ws_fixed    = 0;
    rsp_ready_i = 1'b1;
    got_q.delete();
    got_t.delete();
    send(32'h1A10_2000, 32'h0000_0001, 1'b1);  // now @0
    tick();                                    // @1
    checks++;
    if ({apb_psel_o, apb_penable_o, apb_pwrite_o} !== 3'b101 || apb_paddr_o !== 32'h1A10_2000 ||
        apb_pwdata_o !== 32'h1) begin
      failures++;
      $display("FAIL setup_cycle got sel/en/wr=%b%b%b addr=%h wd=%h exp=101 1a102000 00000001",
               apb_psel_o, apb_penable_o, apb_pwrite_o, apb_paddr_o, apb_pwdata_o);
    end
    tick();                                    // @2
    checks++;
    if ({apb_psel_o, apb_penable_o} !== 2'b11 || apb_pwdata_o !== 32'h1 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL access_cycle got sel/en=%b%b wd=%h rv=%b exp=11 00000001 0",
               apb_psel_o, apb_penable_o, apb_pwdata_o, rsp_valid_o);
    end
    tick();                                    // @3
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd0 || rsp_err_o !== 1'b0 ||
        rsp_timeout_o !== 1'b0 || apb_psel_o !== 1'b0) begin
      failures++;
      $display("FAIL write_rsp got rv=%b rd=%h err=%b to=%b psel=%b exp=1 0 0 0 0",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, apb_psel_o);
    end
    tick();                                    // @4 handshake done
    checks++;
    if (got_q.size() != 1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL write_done got nrsp=%0d busy=%b rv=%b exp=1 0 0", got_q.size(), busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_read_wait();
    int pen = 0;
    ws_fixed    = 3;
    rsp_ready_i = 1'b1;
    got_q.delete();
    send(32'h1A10_2084, 32'h0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (apb_penable_o) pen++;
      if (got_q.size() > 0) break;
    end
    checks++;
    if (pen != 4) begin
      failures++;
      $display("FAIL read_wait_penable got=%0d exp=4", pen);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].rdata !== 32'hDEAD_BEEF || got_q[0].err !== 1'b0 ||
        got_q[0].to !== 1'b0) begin
      failures++;
      $display("FAIL read_wait_rsp got n=%0d exp rdata=deadbeef err=0 to=0", got_q.size());
    end
    ws_fixed = 0;
  endtask

  task automatic test_slverr();
    rsp_ready_i = 1'b1;
    got_q.delete();
    send(32'h1A10_20EC, 32'h1234_5678, 1'b1);
    send(32'h1A10_2084, 32'h0, 1'b0);
    for (int i = 0; i < 30 && got_q.size() < 2; i++) tick();
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL slverr_count got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].err !== 1'b1 || got_q[0].to !== 1'b0 || got_q[0].rdata !== 32'd0) begin
        failures++;
        $display("FAIL slverr_rsp got err=%b to=%b rd=%h exp=1 0 00000000",
                 got_q[0].err, got_q[0].to, got_q[0].rdata);
      end
      checks++;
      if (got_q[1].err !== 1'b0 || got_q[1].rdata !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL after_slverr_rsp got err=%b rd=%h exp=0 deadbeef", got_q[1].err, got_q[1].rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int acc = 0;
    stuck       = 1'b1;
    rsp_ready_i = 1'b1;
    got_q.delete();
    send(32'h1A10_2010, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (apb_psel_o && apb_penable_o) acc++;
      if (got_q.size() > 0) break;
    end
    checks++;
    if (acc != int'(TO)) begin
      failures++;
      $display("FAIL timeout_access_cycles got=%0d exp=%0d", acc, TO);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].err !== 1'b1 || got_q[0].to !== 1'b1 || got_q[0].rdata !== 32'd0) begin
      failures++;
      $display("FAIL timeout_rsp got n=%0d exp err=1 to=1 rdata=0", got_q.size());
    end
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  accepted = 0;
    int  blocked  = 0;
    bit  late_ok  = 1'b0;
    bit  gaps_ok  = 1'b1;
    ws_fixed    = 0;
    rsp_ready_i = 1'b0;
    got_q.delete();
    got_t.delete();
    for (int i = 0; i < 10; i++) begin
      cmd_valid_i = 1'b1;
      cmd_addr_i  = 32'h1A10_2100 + 32'(4 * i);
      cmd_wdata_i = 32'(i);
      cmd_write_i = 1'b1;
      tick();
      if (push_acc) accepted++;
      else break;
    end
    checks++;
    if (accepted != 5) begin
      failures++;
      $display("FAIL full_accept_count got=%0d exp=5", accepted);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!ready_s && !push_acc) blocked++;
    end
    checks++;
    if (blocked != 3) begin
      failures++;
      $display("FAIL full_blocked got=%0d exp=3", blocked);
    end
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (push_acc) begin
        late_ok = 1'b1;
        break;
      end
    end
    cmd_valid_i = 1'b0;
    checks++;
    if (!late_ok) begin
      failures++;
      $display("FAIL sixth_accept got=never exp=accepted_after_rsp");
    end
    for (int i = 0; i < 40 && got_q.size() < 6; i++) tick();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL drain_count got=%0d exp=6", got_q.size());
    end else begin
      for (int i = 1; i < 6; i++) if (got_t[i] - got_t[i-1] != 3) gaps_ok = 1'b0;
      for (int i = 0; i < 6; i++) if (got_q[i].err !== 1'b0 || got_q[i].rdata !== 32'd0) gaps_ok = 1'b0;
      checks++;
      if (!gaps_ok) begin
        failures++;
        $display("FAIL throughput got gap01=%0d gap45=%0d exp=3 each, all rsp ok",
                 got_t[1] - got_t[0], got_t[5] - got_t[4]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit in_acc = 1'b0;
    ws_fixed    = 5;
    rsp_ready_i = 1'b1;
    got_q.delete();
    send(32'h1A10_2300, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (apb_penable_o) begin
        in_acc = 1'b1;
        break;
      end
    end
    sys_resetn_i = 1'b0;
    #1;
    checks++;
    if (!in_acc || apb_psel_o !== 1'b0 || apb_penable_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
        cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got acc=%b psel=%b pen=%b rv=%b rdy=%b busy=%b exp=1 0 0 0 1 0",
               in_acc, apb_psel_o, apb_penable_o, rsp_valid_o, cmd_ready_o, busy_o);
    end
    tick();
    tick();
    sys_resetn_i = 1'b1;
    ws_fixed     = 0;
    tick();
    send(32'h1A10_2304, 32'hCAFE_0001, 1'b1);
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0].err !== 1'b0 || got_q[0].rdata !== 32'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_cmd got n=%0d busy=%b exp=1 0", got_q.size(), busy_o);
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    logic [31:0] mm [logic [31:0]];
    rsp_s exp_q[$];
    rsp_s e;
    rsp_s g;
    int sent = 0;
    int rcvd = 0;
    rand_ws = 1'b1;
    got_q.delete();
    cmd_valid_i = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!cmd_valid_i && sent < N && ($urandom % 3) != 0) begin
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 32'h1A10_3000 | (32'($urandom_range(0, 63)) << 2);
        cmd_wdata_i = $urandom;
        cmd_write_i = 1'($urandom % 2);
      end
      rsp_ready_i = (($urandom % 4) != 0);
      tick();
      if (push_acc) begin
        e.err   = err_rule(cmd_addr_i);
        e.to    = 1'b0;
        e.rdata = cmd_write_i ? 32'd0 : (mm.exists(cmd_addr_i) ? mm[cmd_addr_i] : dflt(cmd_addr_i));
        if (cmd_write_i && !e.err) mm[cmd_addr_i] = cmd_wdata_i;
        exp_q.push_back(e);
        sent++;
        cmd_valid_i = 1'b0;
      end
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        rcvd++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_rsp got rd=%h err=%b exp=no_response", g.rdata, g.err);
        end else begin
          e = exp_q.pop_front();
          if (g.rdata !== e.rdata || g.err !== e.err || g.to !== e.to) begin
            failures++;
            $display("FAIL rand_rsp[%0d] got rd=%h err=%b to=%b exp rd=%h err=%b to=%b",
                     rcvd, g.rdata, g.err, g.to, e.rdata, e.err, e.to);
          end
        end
      end
      if (sent == N && rcvd == N) break;
    end
    checks++;
    if (rcvd != N) begin
      failures++;
      $display("FAIL rand_total got=%0d exp=%0d", rcvd, N);
    end
    rand_ws     = 1'b0;
    rsp_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=bench_complete");
    $fatal(1, "watchdog expired");
  end

endmodule
